// File: rtl/packet_storer.sv
// -----------------------------------------------------------------------------
// packet_storer
//
// Writes one wide packet to memory as six 32-bit words. Words 0..4 are taken
// MSB-first from the latched packet. Word 5 carries the 15-bit tail,
// zero-extended. Each word is issued on the write channel and must be
// acknowledged before the next word goes out. STORE_DONE pulses for one cycle
// once the sixth acknowledge has been received.
//
// Ports
//   CLK, RST             clock (rising edge); synchronous active-high reset
//   OPADDR               packet-region base byte address. It is not latched,
//                        so a change mid-packet moves the remaining writes.
//   RECEIVE_PS_*         store request: byte offset from OPADDR plus packet
//                        data. READY is high only while idle.
//   MEM_SEND_*           word write: address valid and data valid always
//                        match; the transfer completes on MEM_SEND_READY.
//   MEM_RECEIVE_*        write acknowledge; the acknowledge data is unused.
//   STORE_DONE           one-cycle pulse when the whole packet is acknowledged
// -----------------------------------------------------------------------------
module packet_storer #(
   parameter int PACKET_WIDTH = 175
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [31:0]             OPADDR,
   input  logic                    RECEIVE_PS_VALID,
   input  logic [31:0]             RECEIVE_PS_ADDR,
   input  logic [PACKET_WIDTH-1:0] RECEIVE_PS_DATA,
   output logic                    RECEIVE_PS_READY,
   output logic                    MEM_SEND_ADDR_VALID,
   output logic [31:0]             MEM_SEND_ADDR,
   output logic                    MEM_SEND_DATA_VALID,
   output logic [31:0]             MEM_SEND_DATA,
   input  logic                    MEM_SEND_READY,
   input  logic                    MEM_RECEIVE_VALID,
   input  logic [31:0]             MEM_RECEIVE_DATA,
   output logic                    MEM_RECEIVE_READY,
   output logic                    STORE_DONE
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_SEND = 2'd1,
      S_MEM_ACK  = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t                  state_reg;
   logic [2:0]              count_reg;
   logic [PACKET_WIDTH-1:0] packet_reg;
   logic [31:0]             offset_reg;
   logic [31:0]             word_arr [0:5];

   // The acknowledge payload carries no information for this block.
   logic unused_ack_data;
   assign unused_ack_data = ^MEM_RECEIVE_DATA;

   // Slice the latched packet into its six outgoing words.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_word
         assign word_arr[gi] = packet_reg[PACKET_WIDTH-1-32*gi -: 32];
      end
   endgenerate
   assign word_arr[5] = {17'b0, packet_reg[14:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= S_IDLE;
         count_reg  <= 3'd0;
         packet_reg <= '0;
         offset_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (RECEIVE_PS_VALID) begin
                  packet_reg <= RECEIVE_PS_DATA;
                  offset_reg <= RECEIVE_PS_ADDR;
                  count_reg  <= 3'd0;
                  state_reg  <= S_MEM_SEND;
               end
            end
            S_MEM_SEND: begin
               if (MEM_SEND_READY) begin
                  state_reg <= S_MEM_ACK;
               end
            end
            S_MEM_ACK: begin
               if (MEM_RECEIVE_VALID) begin
                  if (count_reg == 3'd5) begin
                     count_reg <= 3'd0;
                     state_reg <= S_DONE;
                  end else begin
                     count_reg <= count_reg + 3'd1;
                     state_reg <= S_MEM_SEND;
                  end
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs decode the state register. The write and ack
   // qualifiers are also masked by RST, so a reset arriving mid-packet drops
   // them in the same cycle instead of one cycle later.
   assign RECEIVE_PS_READY    = (state_reg == S_IDLE);
   assign MEM_SEND_ADDR_VALID = (state_reg == S_MEM_SEND) && !RST;
   assign MEM_SEND_DATA_VALID = MEM_SEND_ADDR_VALID;
   assign MEM_RECEIVE_READY   = (state_reg == S_MEM_ACK) && !RST;
   assign STORE_DONE          = (state_reg == S_DONE) && !RST;

   // The address tracks OPADDR live. The sum wraps modulo 2^32.
   assign MEM_SEND_ADDR = OPADDR + offset_reg + {27'd0, count_reg, 2'b00};

   always_comb begin
      MEM_SEND_DATA = word_arr[0];
      case (count_reg)
         3'd1:    MEM_SEND_DATA = word_arr[1];
         3'd2:    MEM_SEND_DATA = word_arr[2];
         3'd3:    MEM_SEND_DATA = word_arr[3];
         3'd4:    MEM_SEND_DATA = word_arr[4];
         3'd5:    MEM_SEND_DATA = word_arr[5];
         default: MEM_SEND_DATA = word_arr[0];
      endcase
   end

endmodule

// File: doc/packet_storer.md
PACKET_STORER -- requirements
Module: packet_storer

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 175, meaning packet bit width (5 full 32-bit words + 15-bit tail).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port OPADDR  input  32  packet-region base byte address.
REQ-005 SHALL have ports RECEIVE_PS_VALID input 1, RECEIVE_PS_ADDR input 32 (byte offset from OPADDR), RECEIVE_PS_DATA input PACKET_WIDTH, RECEIVE_PS_READY output 1: store-request channel.
REQ-006 SHALL have ports MEM_SEND_ADDR_VALID output 1, MEM_SEND_ADDR output 32, MEM_SEND_DATA_VALID output 1, MEM_SEND_DATA output 32, MEM_SEND_READY input 1: memory write channel.
REQ-007 SHALL have ports MEM_RECEIVE_VALID input 1, MEM_RECEIVE_DATA input 32 (ignored), MEM_RECEIVE_READY output 1: write-acknowledge channel.
REQ-008 SHALL have port STORE_DONE  output  1  one-cycle pulse when a packet is fully written and acknowledged.

Function
REQ-009 SHALL implement states S_IDLE, S_MEM_SEND, S_MEM_ACK, S_DONE.
REQ-010 SHALL drive RECEIVE_PS_READY = 1 iff state is S_IDLE.
REQ-011 SHALL on RECEIVE_PS_VALID && RECEIVE_PS_READY latch RECEIVE_PS_DATA and RECEIVE_PS_ADDR, clear word counter to 0, and go to S_MEM_SEND.
REQ-012 SHALL drive MEM_SEND_ADDR_VALID and MEM_SEND_DATA_VALID both = 1 iff state is S_MEM_SEND; the two SHALL never differ.
REQ-013 SHALL compute MEM_SEND_ADDR = OPADDR + latched offset + 4*count, modulo 2^32 (wrap, no overflow flag).
REQ-014 SHALL send word k (k=0..4) = latched packet bits [PACKET_WIDTH-1-32k -: 32]; word 5 = {17'b0, packet[14:0]}.
REQ-015 SHALL hold address and data stable while valid is high and MEM_SEND_READY is low.
REQ-016 SHALL on MEM_SEND_READY in S_MEM_SEND go to S_MEM_ACK.
REQ-017 SHALL drive MEM_RECEIVE_READY = 1 iff state is S_MEM_ACK; MEM_RECEIVE_VALID outside S_MEM_ACK SHALL be ignored (no state change).
REQ-018 SHALL on MEM_RECEIVE_VALID in S_MEM_ACK: if count == 5 go to S_DONE and clear count; else increment count and go to S_MEM_SEND.
REQ-019 SHALL in S_DONE assert STORE_DONE for exactly one cycle and go to S_IDLE next cycle.
REQ-020 SHALL use a 3-bit word counter ranging 0..5 only.
REQ-021 Minimum latency: request accept at cycle 0, first write valid cycle 1, STORE_DONE at cycle 13 with zero-wait memory; next request acceptable cycle 14.
REQ-022 SHALL not accept a new request while a packet is in progress; OPADDR changes mid-packet SHALL affect subsequent addresses (OPADDR not latched).

Reset
REQ-023 SHALL on RST return to S_IDLE, clear counter, latched data and offset to 0, from any state including mid-packet, abandoning the transfer without STORE_DONE.
REQ-024 SHALL during and the cycle after reset drive MEM_SEND_ADDR_VALID=0, MEM_SEND_DATA_VALID=0, MEM_RECEIVE_READY=0, STORE_DONE=0; RECEIVE_PS_READY=1 from the first cycle after RST deasserts.

Verification
REQ-025 Basic: OPADDR=0x1000, offset=0x40, packet words 0x11111111..0x55555555, tail 0x1234, ready/ack immediate -> six writes at 0x1040,0x1044,...,0x1054, data as given, last 0x00001234, STORE_DONE at cycle 13.
REQ-026 Backpressure: MEM_SEND_READY low 3 cycles on word 2 -> addr/data held constant 4 cycles, no duplicate write, order intact.
REQ-027 Delayed/stray acks: MEM_RECEIVE_VALID pulsed during S_IDLE and S_MEM_SEND -> ignored; ack delayed 5 cycles in S_MEM_ACK -> next word issued only after ack.
REQ-028 Wrap: OPADDR=0xFFFFFFF0, offset=0x8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8, 0xC.
REQ-029 Mid-packet reset: RST asserted after word 3 acked -> valids drop, no STORE_DONE, next request writes from word 0 at new base.
REQ-030 Back-to-back: VALID held high with two queued requests -> second accepted only in S_IDLE after STORE_DONE, RECEIVE_PS_READY low throughout first transfer.
